// File: rtl/seq_pkg.sv
// Shared types and helpers for the task sequencer: state encoding and index-width sizing.
package seq_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      GAP   = 3'd2,
      DONE  = 3'd3,
      FAULT = 3'd4
   } seq_state_t;

   // Width of a task index; a single task still needs a one-bit index port.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Per-task watchdog: counts enabled cycles and flags the last allowed cycle of a task.
module seq_watchdog #(
   parameter int TIMEOUT_CYCLES = 0,
   parameter int WIDTH          = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [WIDTH-1:0] LIMIT = (TIMEOUT_CYCLES > 0) ? WIDTH'(TIMEOUT_CYCLES - 1) : '0;

   logic [WIDTH-1:0] timer;

   // The counter parks at LIMIT so a task that overstays can never wrap back to a safe count.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         timer <= '0;
      end else if (enable && (timer != LIMIT)) begin
         timer <= timer + 1'b1;
      end
   end

   assign expired = (TIMEOUT_CYCLES > 0) && (timer == LIMIT);

endmodule

// File: rtl/task_sequencer.sv
// Runs NUM_TASKS sub-FSMs in order with a level start / pulse stop handshake,
// with go/abort control, optional auto-start and looping, and a per-task watchdog.
module task_sequencer
   import seq_pkg::*;
#(
   parameter int NUM_TASKS      = 3,
   parameter int TIMEOUT_CYCLES = 0,
   parameter int AUTO_START     = 1,
   parameter int LOOP           = 0
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                go,
   input  logic                                abort,
   input  logic [NUM_TASKS-1:0]                stop_task,
   output logic [NUM_TASKS-1:0]                start_task,
   output logic [idx_width(NUM_TASKS)-1:0]     cur_task,
   output logic                                busy,
   output logic                                all_done,
   output logic                                fault,
   output logic [idx_width(NUM_TASKS)-1:0]     fault_task
);

   localparam int                   IDX_W    = idx_width(NUM_TASKS);
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_TASKS - 1);
   localparam int                   WDT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [NUM_TASKS-1:0] ONE_HOT0 = NUM_TASKS'(1);

   seq_state_t       state;
   seq_state_t       next_state;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] next_idx;
   logic [IDX_W-1:0] next_fault_task;
   logic             auto_pending;
   logic             next_auto;
   logic             expired;

   // The timer is held clear outside RUN, so every task starts its budget from zero.
   seq_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .WIDTH         (WDT_W)
   ) u_watchdog (
      .clock  (clock),
      .reset  (reset),
      .clear  (state != RUN),
      .enable (state == RUN),
      .expired(expired)
   );

   always_comb begin
      next_state      = state;
      next_idx        = idx;
      next_auto       = auto_pending;
      next_fault_task = '0;
      if (abort) begin
         next_state = IDLE;
         next_idx   = '0;
         next_auto  = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (go || auto_pending) begin
                  next_state = RUN;
                  next_idx   = '0;
                  next_auto  = 1'b0;
               end
            end
            // A stop on the expiry cycle takes precedence over the watchdog.
            RUN: begin
               if (stop_task[idx]) begin
                  if (idx == LAST_IDX) begin
                     next_state = DONE;
                  end else begin
                     next_state = GAP;
                     next_idx   = idx + 1'b1;
                  end
               end else if (expired) begin
                  next_state      = FAULT;
                  next_fault_task = idx;
               end
            end
            GAP: begin
               next_state = RUN;
            end
            DONE: begin
               if ((LOOP != 0) || go) begin
                  next_state = GAP;
                  next_idx   = '0;
               end
            end
            FAULT: begin
               next_fault_task = fault_task;
            end
            default: begin
               next_state = IDLE;
               next_idx   = '0;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they line up with the state they describe.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         idx          <= '0;
         auto_pending <= (AUTO_START != 0);
         start_task   <= '0;
         cur_task     <= '0;
         busy         <= 1'b0;
         all_done     <= 1'b0;
         fault        <= 1'b0;
         fault_task   <= '0;
      end else begin
         state        <= next_state;
         idx          <= next_idx;
         auto_pending <= next_auto;
         start_task   <= (next_state == RUN) ? (ONE_HOT0 << next_idx) : '0;
         cur_task     <= next_idx;
         busy         <= (next_state == RUN) || (next_state == GAP);
         all_done     <= (next_state == DONE);
         fault        <= (next_state == FAULT);
         fault_task   <= next_fault_task;
      end
   end

endmodule

// File: tb/tb_task_sequencer.sv
// Self-checking bench: dut_a (watchdog 8, no loop) and dut_b (no watchdog, looping).
module tb_task_sequencer;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       reset_a, go_a, abort_a, busy_a, done_a, fault_a;
   logic [2:0] stop_a, start_a;
   logic [1:0] cur_a, ft_a;
   logic       reset_b, go_b, abort_b, busy_b, done_b, fault_b;
   logic [2:0] stop_b, start_b;
   logic [1:0] cur_b, ft_b;

   task_sequencer #(.NUM_TASKS(3), .TIMEOUT_CYCLES(8), .AUTO_START(1), .LOOP(0)) dut_a (
      .clock(clock), .reset(reset_a), .go(go_a), .abort(abort_a), .stop_task(stop_a),
      .start_task(start_a), .cur_task(cur_a), .busy(busy_a), .all_done(done_a),
      .fault(fault_a), .fault_task(ft_a));

   task_sequencer #(.NUM_TASKS(3), .TIMEOUT_CYCLES(0), .AUTO_START(1), .LOOP(1)) dut_b (
      .clock(clock), .reset(reset_b), .go(go_b), .abort(abort_b), .stop_task(stop_b),
      .start_task(start_b), .cur_task(cur_b), .busy(busy_b), .all_done(done_b),
      .fault(fault_b), .fault_task(ft_b));

   // Expected outputs packed as {start_task, cur_task, busy, all_done, fault, fault_task}.
   typedef struct {
      logic       rst;
      logic       go;
      logic       abort;
      logic [2:0] stop;
      logic [9:0] exp;
   } vec_t;

   vec_t       vec_a[$];
   logic [9:0] expq[$];
   int         checks = 0;
   int         fails  = 0;

   function automatic logic [9:0] outs(input logic [2:0] st, input int cur, input logic bz,
                                       input logic dn, input logic ft, input int ftask);
      logic [1:0] c, f;
      c = 2'(cur);
      f = 2'(ftask);
      return {st, c, bz, dn, ft, f};
   endfunction

   function automatic logic [9:0] idle_o();
      return outs(3'b000, 0, 1'b0, 1'b0, 1'b0, 0);
   endfunction
   function automatic logic [9:0] run_o(input int i);
      return outs(3'(1 << i), i, 1'b1, 1'b0, 1'b0, 0);
   endfunction
   function automatic logic [9:0] gap_o(input int i);
      return outs(3'b000, i, 1'b1, 1'b0, 1'b0, 0);
   endfunction
   function automatic logic [9:0] done_o();
      return outs(3'b000, 2, 1'b0, 1'b1, 1'b0, 0);
   endfunction
   function automatic logic [9:0] fault_o(input int t);
      return outs(3'b000, t, 1'b0, 1'b0, 1'b1, t);
   endfunction

   function automatic vec_t mk(input logic rst, input logic go, input logic abort,
                               input logic [2:0] stop, input logic [9:0] exp);
      vec_t v;
      v.rst = rst; v.go = go; v.abort = abort; v.stop = stop; v.exp = exp;
      return v;
   endfunction

   task automatic checkOutput(input int sel, input int step);
      logic [9:0] act, exp;
      act = (sel == 0) ? {start_a, cur_a, busy_a, done_a, fault_a, ft_a}
                       : {start_b, cur_b, busy_b, done_b, fault_b, ft_b};
      checks++;
      if (expq.size() == 0) begin
         fails++;
         $display("[TB] FAIL scoreboard_empty dut=%0d step %0d: got %b, no expectation queued", sel, step, act);
      end else begin
         exp = expq.pop_front();
         if (act !== exp) begin
            fails++;
            $display("[TB] FAIL outputs dut=%0d step %0d: got %b expected %b", sel, step, act, exp);
         end
      end
   endtask

   task automatic applyStimulus(input int sel, input vec_t v, input int step);
      @(negedge clock);
      if (sel == 0) begin
         reset_a = v.rst; go_a = v.go; abort_a = v.abort; stop_a = v.stop;
      end else begin
         reset_b = v.rst; go_b = v.go; abort_b = v.abort; stop_b = v.stop;
      end
      expq.push_back(v.exp);
      @(posedge clock);
      #1;
      checkOutput(sel, step);
   endtask

   initial begin
      int step;
      reset_a = 1'b1; go_a = 1'b0; abort_a = 1'b0; stop_a = 3'b000;
      reset_b = 1'b1; go_b = 1'b0; abort_b = 1'b0; stop_b = 3'b000;

      // Reset release, auto-start, handshake timing, spurious stops, DONE hold.
      vec_a.push_back(mk(1, 0, 0, 3'b000, idle_o()));
      vec_a.push_back(mk(0, 0, 0, 3'b000, run_o(0)));
      for (int i = 0; i < 3; i++) vec_a.push_back(mk(0, 0, 0, 3'b000, run_o(0)));
      vec_a.push_back(mk(0, 0, 0, 3'b001, gap_o(1)));
      vec_a.push_back(mk(0, 0, 0, 3'b000, run_o(1)));
      vec_a.push_back(mk(0, 0, 0, 3'b101, run_o(1)));
      vec_a.push_back(mk(0, 0, 0, 3'b101, run_o(1)));
      vec_a.push_back(mk(0, 0, 0, 3'b010, gap_o(2)));
      vec_a.push_back(mk(0, 0, 0, 3'b000, run_o(2)));
      vec_a.push_back(mk(0, 0, 0, 3'b100, done_o()));
      vec_a.push_back(mk(0, 0, 0, 3'b000, done_o()));
      vec_a.push_back(mk(0, 0, 0, 3'b111, done_o()));
      // Restart from DONE, then let task 0 time out.
      vec_a.push_back(mk(0, 1, 0, 3'b000, gap_o(0)));
      vec_a.push_back(mk(0, 0, 0, 3'b000, run_o(0)));
      for (int i = 0; i < 7; i++) vec_a.push_back(mk(0, 0, 0, 3'b000, run_o(0)));
      vec_a.push_back(mk(0, 0, 0, 3'b000, fault_o(0)));
      vec_a.push_back(mk(0, 1, 0, 3'b000, fault_o(0)));
      vec_a.push_back(mk(0, 0, 1, 3'b000, idle_o()));
      vec_a.push_back(mk(0, 0, 0, 3'b000, idle_o()));
      // Stop landing on the expiry cycle must win over the watchdog.
      vec_a.push_back(mk(0, 1, 0, 3'b000, run_o(0)));
      for (int i = 0; i < 7; i++) vec_a.push_back(mk(0, 0, 0, 3'b000, run_o(0)));
      vec_a.push_back(mk(0, 0, 0, 3'b001, gap_o(1)));
      vec_a.push_back(mk(0, 0, 0, 3'b000, run_o(1)));
      vec_a.push_back(mk(0, 0, 1, 3'b010, idle_o()));
      // Reset in the middle of a run, then auto-start re-arms.
      vec_a.push_back(mk(0, 1, 0, 3'b000, run_o(0)));
      vec_a.push_back(mk(0, 0, 0, 3'b000, run_o(0)));
      vec_a.push_back(mk(1, 0, 0, 3'b000, idle_o()));
      vec_a.push_back(mk(0, 0, 0, 3'b000, run_o(0)));

      foreach (vec_a[i]) applyStimulus(0, vec_a[i], i);
      @(negedge clock);
      reset_a = 1'b1;

      // Looping instance: long task 0 without watchdog, then three full loops.
      step = 0;
      applyStimulus(1, mk(1, 0, 0, 3'b000, idle_o()), step++);
      applyStimulus(1, mk(0, 0, 0, 3'b000, run_o(0)), step++);
      for (int i = 0; i < 12; i++) applyStimulus(1, mk(0, 0, 0, 3'b000, run_o(0)), step++);
      for (int loop = 0; loop < 3; loop++) begin
         applyStimulus(1, mk(0, 0, 0, 3'b001, gap_o(1)), step++);
         applyStimulus(1, mk(0, 0, 0, 3'b000, run_o(1)), step++);
         applyStimulus(1, mk(0, 0, 0, 3'b010, gap_o(2)), step++);
         applyStimulus(1, mk(0, 0, 0, 3'b000, run_o(2)), step++);
         applyStimulus(1, mk(0, 0, 0, 3'b100, done_o()), step++);
         applyStimulus(1, mk(0, 0, 0, 3'b000, gap_o(0)), step++);
         applyStimulus(1, mk(0, 0, 0, 3'b000, run_o(0)), step++);
      end
      applyStimulus(1, mk(0, 1, 1, 3'b001, idle_o()), step++);
      applyStimulus(1, mk(0, 0, 0, 3'b000, idle_o()), step++);
      applyStimulus(1, mk(0, 1, 0, 3'b000, run_o(0)), step++);

      if (expq.size() != 0) begin
         fails++;
         $display("[TB] FAIL scoreboard_leftover: got %0d pending entries, expected 0", expq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/task_sequencer.md
Name: task_sequencer

Overview:
- Parametrised top-level controller that runs NUM_TASKS sub-FSMs in order using a start/stop handshake.
- Typical sequence: init memory, then shuffle, then decrypt.
- Generalises the single-task controller. Adds:
  - task count as a parameter
  - go/abort control
  - optional auto-start after reset
  - optional looping
  - a per-task watchdog timeout with fault reporting

Parameters:
- NUM_TASKS, 3, number of sequenced tasks (1..16).
- TIMEOUT_CYCLES, 0, watchdog limit in cycles per task; 0 disables the watchdog.
- AUTO_START, 1, 1 = start the sequence once after reset without needing go.
- LOOP, 0, 1 = restart at task 0 after the last task completes.

Ports:
- clock, input, 1, system clock; all logic is on the rising edge.
- reset, input, 1, synchronous active-high reset.
- go, input, 1, request to start or restart the sequence; sampled only in IDLE and DONE.
- abort, input, 1, return to IDLE from any state.
- stop_task, input, NUM_TASKS, per-task completion; bit i is meaningful only while task i is active.
- start_task, output, NUM_TASKS, per-task start level; one-hot or zero, registered.
- cur_task, output, IDX_W = max(1, clog2(NUM_TASKS)), index of the active or last task.
- busy, output, 1, high in RUN and GAP.
- all_done, output, 1, high in DONE.
- fault, output, 1, high in FAULT.
- fault_task, output, IDX_W, index of the task that timed out; valid while fault is high.

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is synchronous and active-high, and has priority over every other input.
- Reset values:
  - state = IDLE, idx = 0, timer = 0, auto_pending = AUTO_START.
  - start_task = 0, cur_task = 0, busy = 0, all_done = 0, fault = 0, fault_task = 0.
- States: IDLE, RUN, GAP, DONE, FAULT.
- Outputs are registered and are decoded from state and idx.
  - start_task[idx] = 1 only in RUN.
- IDLE:
  - If go or auto_pending: next state RUN, idx = 0, timer = 0, auto_pending cleared.
  - go at cycle n puts start_task[0] high at cycle n+1.
- RUN:
  - start_task[idx] is held high (level, not pulse) until stop_task[idx] is sampled high.
  - stop_task bits other than idx are ignored.
  - On stop_task[idx] with idx < NUM_TASKS-1: go to GAP with idx+1.
  - On stop_task[idx] with idx = NUM_TASKS-1: go to DONE.
- GAP:
  - Exactly one cycle with all start_task low, so each task sees a fresh rising edge.
  - Then RUN with timer = 0.
  - Handshake timing: stop_task[i] high at cycle n gives start_task[i] low at n+1 and start_task[i+1] high at n+2.
- Watchdog (only when TIMEOUT_CYCLES > 0):
  - timer increments every RUN cycle.
  - If timer = TIMEOUT_CYCLES-1 and stop_task[idx] is low: go to FAULT and capture fault_task = idx.
  - stop_task arriving on the expiry cycle wins: no fault is raised.
  - timer saturates and never wraps.
- DONE:
  - all_done = 1 and cur_task = NUM_TASKS-1.
  - If LOOP = 1: after one cycle, go to GAP with idx = 0.
  - If LOOP = 0: remain in DONE until go, then go to GAP with idx = 0.
- FAULT:
  - start_task all 0, fault = 1.
  - Sticky: leaves only via abort or reset, to IDLE. go is ignored.
- abort:
  - Any state goes to IDLE next cycle: start_task = 0, idx = 0, fault cleared.
  - abort beats a simultaneous go or stop_task.
  - auto_pending is not re-armed by abort.
- NUM_TASKS = 1: GAP is used only on restart from DONE.
- Illegal state encoding recovers to IDLE.

Decomposition:
- Package seq_pkg holds:
  - the state enum type seq_state_t
  - the function idx_width(n)
- Sub-module seq_watchdog contains:
  - parameters TIMEOUT_CYCLES and width
  - inputs clear and enable
  - output expired
  - Tie expired = 0 when TIMEOUT_CYCLES = 0.
- Everything else stays in task_sequencer.

Test Plan:
- Reset release, default parameters (NUM_TASKS=3, AUTO_START=1):
  - start_task = 3'b001 on the first cycle after reset deasserts.
  - stop_task[0] pulsed at cycle 5 -> start_task = 000 at cycle 6 and 010 at cycle 7.
  - After all three stops, all_done = 1 and remains 1 with LOOP=0.
- Spurious stops:
  - While task 1 is active, drive stop_task = 3'b101 -> no transition; start_task stays 010.
- Watchdog (TIMEOUT_CYCLES=8):
  - Never assert stop_task[0] -> fault = 1 and fault_task = 0 exactly 8 cycles after start_task[0] rose; start_task = 0.
  - go is then ignored; abort returns to IDLE with fault = 0.
- Watchdog boundary:
  - stop_task[idx] on the expiry cycle -> fault stays 0 and the sequence advances.
- LOOP=1:
  - After the last stop -> all_done high for 1 cycle, one GAP cycle, then start_task = 001 again; repeat 3 loops.
- abort and reset priority:
  - abort together with stop_task[1] -> IDLE; start_task = 0 and cur_task = 0 next cycle.
  - AUTO_START does not re-fire after abort; go re-launches task 0.
  - reset asserted mid-RUN -> all outputs at reset values on the next edge.
